// File: rtl/csa_pkg.sv
// Shared defaults and helpers for the pipelined carry-skip adder.
package csa_pkg;
  localparam int CSA_WIDTH = 32;
  localparam int CSA_BLK   = 4;
  localparam int CSA_BPS   = 2;

  function automatic int nstg(input int width, input int blk, input int bps);
    return width / (blk * bps);
  endfunction
endpackage

// File: rtl/pipelined_carry_skip_adder_if.sv
// Valid/ready operand and result bus of the carry-skip adder.
// The optional sub input exists only when CSA_SUB_EN is defined.
interface pipelined_carry_skip_adder_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef CSA_SUB_EN
  logic             sub;

  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, ovf);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, ovf);
`endif
endinterface

// File: rtl/csa_block.sv
// Combinational BLK-bit ripple adder with a carry-skip bypass.
module csa_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);
  logic [BLK-1:0] p;
  logic [BLK:0]   c;

  always_comb begin
    p    = a ^ b;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < BLK; i++) begin
      s[i]   = p[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    end
    // all-propagate block: the block carry-in passes straight through
    cout = (&p) ? cin : c[BLK];
  end
endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Carry-skip adder split into NSTG register stages of BLK*BPS bits each.
// Define CSA_SUB_EN to add the sub input (a - b when sub=1, cin=0).
module pipelined_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLK   = CSA_BLK,
  parameter int BPS   = CSA_BPS
) (
  input logic                         clk,
  input logic                         rst,
  pipelined_carry_skip_adder_if.slave bus
);
  localparam int SW   = BLK * BPS;
  localparam int NSTG = nstg(WIDTH, BLK, BPS);

  if (WIDTH % SW != 0) begin : g_width_chk
    $error("WIDTH must be a multiple of BLK*BPS");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             adv;
  logic [NSTG-1:0]  vld_pipe;

`ifdef CSA_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.cin | bus.sub;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  // whole pipeline moves in lockstep; a stall freezes every stage
  assign adv          = !vld_pipe[NSTG-1] | bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_pipe <= '0;
    else if (adv) vld_pipe <= NSTG'({vld_pipe, bus.in_valid});
  end

  for (genvar k = 0; k < NSTG; k++) begin : stg
    logic [SW-1:0]       sa, sb, ss;
    logic [BPS:0]        c;
    logic [(k+1)*SW-1:0] s_d, s_q;
    logic                c_q;

    if (k == 0) begin : g_in
      assign sa   = bus.a[SW-1:0];
      assign sb   = b_eff[SW-1:0];
      assign c[0] = cin_eff;
      assign s_d  = ss;
    end else begin : g_in
      assign sa   = stg[k-1].g_op.a_q[SW-1:0];
      assign sb   = stg[k-1].g_op.b_q[SW-1:0];
      assign c[0] = stg[k-1].c_q;
      assign s_d  = {ss, stg[k-1].s_q};
    end

    for (genvar j = 0; j < BPS; j++) begin : blk
      csa_block #(.BLK(BLK)) u_blk (
        .a    (sa[j*BLK +: BLK]),
        .b    (sb[j*BLK +: BLK]),
        .cin  (c[j]),
        .s    (ss[j*BLK +: BLK]),
        .cout (c[j+1])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        s_q <= s_d;
        c_q <= c[BPS];
      end
    end

    // operand bits still waiting for later stages
    if (k < NSTG-1) begin : g_op
      logic [WIDTH-(k+1)*SW-1:0] a_d, b_d, a_q, b_q;

      if (k == 0) begin : g_src
        assign a_d = bus.a[WIDTH-1:SW];
        assign b_d = b_eff[WIDTH-1:SW];
      end else begin : g_src
        assign a_d = stg[k-1].g_op.a_q[WIDTH-k*SW-1:SW];
        assign b_d = stg[k-1].g_op.b_q[WIDTH-k*SW-1:SW];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    // the last slice holds the MSB, so overflow is decided here
    if (k == NSTG-1) begin : g_last
      logic ovf_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_q <= 1'b0;
        else if (adv) ovf_q <= (sa[SW-1] == sb[SW-1]) & (ss[SW-1] != sa[SW-1]);
      end
    end
  end

  assign bus.out_valid = vld_pipe[NSTG-1];
  assign bus.sum       = stg[NSTG-1].s_q;
  assign bus.cout      = stg[NSTG-1].c_q;
  assign bus.ovf       = stg[NSTG-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench: directed spec cases, backpressure, mid-flight reset
// and a randomized run scored against an arithmetic reference model.
module tb_pipelined_carry_skip_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic cur_sub = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_carry_skip_adder_if #(.WIDTH(W)) bus ();

  pipelined_carry_skip_adder #(.WIDTH(W), .BLK(4), .BPS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   t;
    res_t         r;
    bb    = sub ? ~b : b;
    t     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (cin | sub)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
`ifdef CSA_SUB_EN
    bus.sub      = cur_sub;
`endif
  endtask

  function automatic res_t cur_res();
    return {bus.sum, bus.cout, bus.ovf};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.out_valid, cur_res()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {bus.out_valid, cur_res()});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  // one operand, exact latency of two cycles, spec-given expected result
  task automatic test_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input res_t exp);
    drive(1'b1, a, b, cin);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready got %b want 1", name, bus.in_ready);
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid got %b want 0", name, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, cur_res()} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL %s_result: got v=%b %h/%b/%b want v=1 %h/%b/%b", name, bus.out_valid,
               bus.sum, bus.cout, bus.ovf, exp.sum, exp.cout, exp.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] oa[3], ob[3];
    logic         oc[3];
    res_t         r[3];
    for (int i = 0; i < 3; i++) begin
      oa[i] = W'($urandom);
      ob[i] = W'($urandom);
      oc[i] = 1'($urandom);
      r[i]  = model(oa[i], ob[i], oc[i], 1'b0);
    end
    bus.out_ready = 1'b1;
    drive(1'b1, oa[0], ob[0], oc[0]);
    @(posedge clk); #1;
    drive(1'b1, oa[1], ob[1], oc[1]);
    @(posedge clk); #1;
    drive(1'b1, oa[2], ob[2], oc[2]);
    bus.out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_in_ready[%0d]: got %b want 0", h, bus.in_ready);
      end
      checks++;
      if ({bus.out_valid, cur_res()} !== {1'b1, r[0]}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", h, bus.out_valid,
                 cur_res(), r[0]);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, cur_res()} !== {1'b1, r[i]}) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got v=%b %h want v=1 %h", i, bus.out_valid,
                 cur_res(), r[i]);
      end
      @(posedge clk); #1;
      drive(1'b0, '0, '0, 1'b0);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid got %b want 0", bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight;
    res_t e;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'hAAAA, 16'h5555, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, cur_res()} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0", {bus.out_valid, cur_res()});
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale[%0d]: out_valid got %b want 0", i, bus.out_valid);
      end
    end
    @(posedge clk); #1;
    e = model(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    test_single("rst_after", 16'h0F0F, 16'h0101, 1'b1, e);
  endtask

  task automatic test_random;
    res_t         q[$];
    res_t         e;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic         was_held = 1'b0;
    int           n;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0:       begin ra = 16'hFFFF; rb = W'($urandom_range(0, 1)); end
        1:       begin ra = W'($urandom); rb = ~ra; end
        2:       begin ra = 16'h7FFF; rb = W'($urandom_range(0, 3)); end
        default: begin ra = W'($urandom); rb = W'($urandom); end
      endcase
      rc = 1'($urandom);
`ifdef CSA_SUB_EN
      cur_sub = 1'($urandom);
`endif
      drive(1'($urandom_range(0, 3) != 0), ra, rb, rc);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (was_held) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL rand_hold[%0d]: out_valid got %b want 1", i, bus.out_valid);
        end
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious[%0d]: out_valid got 1 want 0", i);
        end else if (cur_res() !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: got %h/%b/%b want %h/%b/%b", i, bus.sum,
                   bus.cout, bus.ovf, q[0].sum, q[0].cout, q[0].ovf);
        end
        if (bus.out_ready && q.size() != 0) e = q.pop_front();
      end
      was_held = bus.out_valid & !bus.out_ready;
      if (bus.in_valid && bus.in_ready) q.push_back(model(ra, rb, rc, cur_sub));
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        e = q.pop_front();
        checks++;
        if (cur_res() !== e) begin
          errors++;
          $display("FAIL rand_drain: got %h want %h", cur_res(), e);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL rand_drain_timeout: %0d results missing, want 0", q.size());
    end
`ifdef CSA_SUB_EN
    cur_sub = 1'b0;
`endif
  endtask

`ifdef CSA_SUB_EN
  task automatic test_sub;
    cur_sub = 1'b1;
    test_single("sub", 16'h0005, 16'h0007, 1'b0, '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
    cur_sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single("carry", 16'hFFFF, 16'h0001, 1'b0, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    test_single("skip",  16'h00FF, 16'hFF00, 1'b1, '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0});
    test_single("ovf",   16'h7FFF, 16'h0001, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    test_back_to_back();
    test_reset_midflight();
`ifdef CSA_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
